cpu_run_ctrl: RTL



---
 rtl/cpu_run_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/step/breakpoint controller producing the CPU enable strobe. Supports
// HALT, free RUN at a slow or turbo rate, single STEP, and an automatic stop
// (BREAK) when the instruction pointer matches a breakpoint address on a tick.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous reset, active-high
//   run_req      in   1-cycle pulse: start/resume free run
//   step_req     in   1-cycle pulse: issue exactly one enable
//   halt_req     in   1-cycle pulse: stop running
//   turbo        in   level: 1 selects TURBO_CNT, 0 selects SLOW_CNT
//   bp_en        in   breakpoint enable (level)
//   bp_addr[7:0] in   breakpoint instruction address
//   ip[7:0]      in   current CPU instruction pointer
//   enable       out  CPU enable strobe, one cycle wide, registered
//   state[1:0]   out  00 HALT, 01 RUN, 10 STEP, 11 BREAK
//   bp_hit       out  high while in BREAK
//   enable_count out  enables issued since reset (wraps)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int SLOW_CNT  = 10_000_000,
    parameter int TURBO_CNT = 1_000_000,
    parameter int CNT_W     = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic        turbo,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  ip,
    output logic        enable,
    output logic [1:0]  state,
    output logic        bp_hit,
    output logic [15:0] enable_count
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] SLOW_M1  = CNT_W'(SLOW_CNT - 1);
    localparam logic [CNT_W-1:0] TURBO_M1 = CNT_W'(TURBO_CNT - 1);

    state_t           cur_state, nxt_state;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             skip, skip_nxt;
    logic             fire;
    logic [CNT_W-1:0] period_m1;
    logic             tick;
    logic             bp_match;

    // Period is re-evaluated every cycle; ">=" makes a mid-run switch to a
    // shorter period tick immediately when the counter is already past it.
    assign period_m1 = turbo ? TURBO_M1 : SLOW_M1;
    assign tick      = (cnt >= period_m1);
    assign bp_match  = bp_en && (ip == bp_addr) && !skip;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        nxt_state = cur_state;
        cnt_nxt   = cnt;
        skip_nxt  = skip;
        fire      = 1'b0;

        unique case (cur_state)
            ST_HALT: begin
                // A coincident halt_req outranks step/run and does nothing here.
                if (halt_req) begin
                    nxt_state = ST_HALT;
                end else if (step_req) begin
                    nxt_state = ST_STEP;
                end else if (run_req) begin
                    nxt_state = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    // Any enable due on this cycle is dropped.
                    nxt_state = ST_HALT;
                    cnt_nxt   = '0;
                    skip_nxt  = 1'b0;
                end else if (tick) begin
                    cnt_nxt = '0;
                    if (bp_match) begin
                        nxt_state = ST_BREAK;
                    end else begin
                        fire     = 1'b1;
                        skip_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_STEP: begin
                nxt_state = ST_HALT;
                skip_nxt  = 1'b0;
            end
            ST_BREAK: begin
                if (halt_req) begin
                    nxt_state = ST_HALT;
                    skip_nxt  = 1'b0;
                end else if (step_req) begin
                    nxt_state = ST_STEP;
                end else if (run_req) begin
                    // Skip lets execution move past the breakpoint address.
                    nxt_state = ST_RUN;
                    cnt_nxt   = '0;
                    skip_nxt  = 1'b1;
                end
            end
            default: nxt_state = ST_HALT;
        endcase

        // Entering STEP issues its single enable.
        if (nxt_state == ST_STEP) begin
            fire = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state    <= ST_HALT;
            cnt          <= '0;
            skip         <= 1'b0;
            enable       <= 1'b0;
            bp_hit       <= 1'b0;
            enable_count <= '0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
            skip      <= skip_nxt;
            enable    <= fire;
            bp_hit    <= (nxt_state == ST_BREAK);
            if (fire) begin
                enable_count <= enable_count + 16'd1;
            end
        end
    end

    assign state = cur_state;

endmodule
